// File: rtl/dmem_mmio_bridge.sv
// dmem_mmio_bridge: steers processor dmem accesses to the data RAM, an 8-word MMIO window, or nowhere.
// Latency: loads are combinational (same cycle); a TX push is visible on tx_data one cycle later.
// Backpressure: tx_ready holds the FIFO head; a push into a full FIFO with no pop is dropped and flagged.

module dmem_mmio_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy,
  output logic [AW:0]  count
);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;

  // Handshakes and pointer/occupancy update; a full FIFO still accepts a push when the head leaves this cycle.
  always_comb begin
    out_vld  = (count_q != '0);
    pop      = out_vld & out_rdy;
    in_rdy   = (count_q != CNT_FULL) | pop;
    push     = in_vld & in_rdy;
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (push & ~pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop & ~push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  assign out_dat = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Control state; reset empties the FIFO and leaves storage untouched.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_dat;
    end
  end
endmodule

module dmem_mmio_bridge #(
  parameter int          RAM_ADDR_BITS = 12,
  parameter logic [31:0] MMIO_BASE     = 32'h0000F000,
  parameter int          FIFO_DEPTH    = 16,
  parameter int          IN_WIDTH      = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [31:0]              address_dmem,
  input  logic [31:0]              data,
  input  logic                     wren,
  output logic [31:0]              q_dmem,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic [31:0]              ram_data,
  output logic                     ram_wren,
  input  logic [31:0]              ram_q,
  output logic [31:0]              tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  input  logic [IN_WIDTH-1:0]      ext_in
);
  localparam int         CW            = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0] OFS_TX_DATA   = 3'd0;
  localparam logic [2:0] OFS_TX_STATUS = 3'd1;
  localparam logic [2:0] OFS_INPUT     = 3'd2;
  localparam logic [2:0] OFS_CYCLE     = 3'd3;
  localparam logic [2:0] OFS_EDGE      = 3'd4;

  logic                ram_hit, mmio_hit, mmio_wr;
  logic [2:0]          ofs;
  logic                tx_push, tx_in_rdy, tx_full, tx_empty;
  logic [CW-1:0]       tx_count;
  logic [31:0]         status, mmio_rdat;
  logic [IN_WIDTH-1:0] w1c;
  logic                overflow_q, overflow_d;
  logic [IN_WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [IN_WIDTH-1:0] edge_q, edge_d;
  logic [31:0]         cycle_q, cycle_d;

  // Address decode and the pass-through RAM port.
  always_comb begin
    ram_hit  = (address_dmem[31:RAM_ADDR_BITS] == '0);
    mmio_hit = (address_dmem[31:3] == MMIO_BASE[31:3]);
    ofs      = address_dmem[2:0];
    mmio_wr  = wren & mmio_hit;
    ram_addr = address_dmem[RAM_ADDR_BITS-1:0];
    ram_data = data;
    ram_wren = wren & ram_hit;
    tx_push  = mmio_wr & (ofs == OFS_TX_DATA);
  end

  dmem_mmio_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock   (clock),
    .reset   (reset),
    .in_vld  (tx_push),
    .in_dat  (data),
    .in_rdy  (tx_in_rdy),
    .out_vld (tx_valid),
    .out_dat (tx_data),
    .out_rdy (tx_ready),
    .count   (tx_count)
  );

  assign tx_full  = (tx_count == CW'(FIFO_DEPTH));
  assign tx_empty = ~tx_valid;

  // Next-state for MMIO registers; a new edge beats a same-cycle W1C on that bit.
  always_comb begin
    overflow_d = overflow_q;
    if (mmio_wr & (ofs == OFS_TX_STATUS)) begin
      overflow_d = 1'b0;
    end else if (tx_push & ~tx_in_rdy) begin
      overflow_d = 1'b1;
    end
    sync1_d = ext_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    w1c     = '0;
    if (mmio_wr & (ofs == OFS_EDGE)) begin
      w1c = data[IN_WIDTH-1:0];
    end
    edge_d  = (edge_q & ~w1c) | (sync2_q & ~prev_q);
    cycle_d = (mmio_wr & (ofs == OFS_CYCLE)) ? data : cycle_q + 32'd1;
  end

  // MMIO register state.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q <= 1'b0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      edge_q     <= '0;
      cycle_q    <= '0;
    end else begin
      overflow_q <= overflow_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      edge_q     <= edge_d;
      cycle_q    <= cycle_d;
    end
  end

  // Load data mux: RAM, selected MMIO register, or zero for unmapped space.
  always_comb begin
    status          = '0;
    status[5 +: CW] = tx_count;
    status[4]       = overflow_q;
    status[1]       = tx_full;
    status[0]       = tx_empty;
    mmio_rdat       = '0;
    case (ofs)
      OFS_TX_STATUS: mmio_rdat = status;
      OFS_INPUT:     mmio_rdat[IN_WIDTH-1:0] = sync2_q;
      OFS_CYCLE:     mmio_rdat = cycle_q;
      OFS_EDGE:      mmio_rdat[IN_WIDTH-1:0] = edge_q;
      default:       mmio_rdat = '0;
    endcase
    if (ram_hit) begin
      q_dmem = ram_q;
    end else if (mmio_hit) begin
      q_dmem = mmio_rdat;
    end else begin
      q_dmem = '0;
    end
  end
endmodule

// File: tb/tb_dmem_mmio_bridge.sv
`timescale 1ns/1ps
module tb_dmem_mmio_bridge;
  localparam logic [31:0] TXD = 32'h0000F000;
  localparam logic [31:0] STS = 32'h0000F001;
  localparam logic [31:0] INP = 32'h0000F002;
  localparam logic [31:0] CYC = 32'h0000F003;
  localparam logic [31:0] EDG = 32'h0000F004;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address_dmem = '0;
  logic [31:0] data = '0;
  logic        wren = 1'b0;
  logic [31:0] ram_q = '0;
  logic        tx_ready = 1'b0;
  logic [7:0]  ext_in = '0;
  logic [31:0] q_dmem, ram_data, tx_data;
  logic [11:0] ram_addr;
  logic        ram_wren, tx_valid;

  int          n_checks = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] r;

  dmem_mmio_bridge dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .ram_addr     (ram_addr),
    .ram_data     (ram_data),
    .ram_wren     (ram_wren),
    .ram_q        (ram_q),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .ext_in       (ext_in)
  );

  always #50 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] q);
    address_dmem = a;
    wren = 1'b0;
    #1;
    q = q_dmem;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    address_dmem = a;
    data = d;
    wren = 1'b1;
    cyc();
    wren = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d, input bit accept);
    if (accept) exp_q.push_back(d);
    store(TXD, d);
  endtask

  // Scoreboard side: every word leaving the FIFO must match the oldest expected word.
  always @(negedge clock) begin
    if (!reset && tx_valid && tx_ready) begin
      check("tx_pop_expected", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) check("tx_data", tx_data, exp_q.pop_front());
    end
  end

  initial begin
    cyc();
    cyc();
    reset = 1'b0;
    check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    rd(STS, r); check("rst_status", r, 32'h1);
    rd(CYC, r); check("rst_cycle", r, 32'd0);
    rd(EDG, r); check("rst_edge", r, 32'd0);
    cyc();
    rd(CYC, r); check("cycle_incr", r, 32'd1);

    // RAM path and decode boundaries
    address_dmem = 32'd5; data = 32'hABCD; wren = 1'b1; #1;
    check("ram_wren", {31'b0, ram_wren}, 32'd1);
    check("ram_addr", {20'b0, ram_addr}, 32'd5);
    check("ram_data", ram_data, 32'hABCD);
    cyc();
    wren = 1'b0;
    ram_q = 32'hABCD;
    rd(32'd5, r);      check("ram_load", r, 32'hABCD);
    rd(32'hFFF, r);    check("ram_top", r, 32'hABCD);
    rd(32'h1000, r);   check("unmapped_1000", r, 32'd0);
    rd(32'h8000, r);   check("unmapped_8000", r, 32'd0);

    // Three queued words, then drain
    for (int i = 1; i <= 3; i++) push_word(32'(i), 1'b1);
    check("tx_valid_q3", {31'b0, tx_valid}, 32'd1);
    rd(STS, r); check("status_cnt3", r, 32'h60);
    cyc();
    check("tx_head_stable", tx_data, 32'd1);
    tx_ready = 1'b1;
    repeat (3) cyc();
    check("tx_valid_drained", {31'b0, tx_valid}, 32'd0);
    check("sb_drained_1", 32'(exp_q.size()), 32'd0);
    tx_ready = 1'b0;

    // Overflow, clear, push-while-full with pop
    for (int i = 0; i < 17; i++) push_word(32'h100 + 32'(i), i < 16);
    rd(STS, r); check("status_full_ovf", r, 32'h212);
    check("tx_head_full", tx_data, 32'h100);
    store(STS, 32'd0);
    rd(STS, r); check("status_ovf_clr", r, 32'h202);
    tx_ready = 1'b1;
    push_word(32'h777, 1'b1);
    rd(STS, r); check("status_full_pushpop", r, 32'h202);
    repeat (16) cyc();
    check("tx_valid_drained2", {31'b0, tx_valid}, 32'd0);
    check("sb_drained_2", 32'(exp_q.size()), 32'd0);
    tx_ready = 1'b0;

    // Input synchronizer and edge latch
    ext_in = 8'h01;
    cyc();
    rd(INP, r); check("input_1cyc", r, 32'd0);
    cyc();
    rd(INP, r); check("input_2cyc", r, 32'd1);
    cyc();
    rd(EDG, r); check("edge_set", r, 32'd1);
    store(EDG, 32'd1);
    rd(EDG, r); check("edge_w1c", r, 32'd0);
    store(INP, 32'd0);
    rd(INP, r); check("input_wr_ignored", r, 32'd1);
    ext_in = 8'h00;
    repeat (3) cyc();
    rd(EDG, r); check("edge_fall_ignored", r, 32'd0);
    ext_in = 8'h01;
    cyc();
    cyc();
    store(EDG, 32'd1);
    rd(EDG, r); check("edge_set_wins", r, 32'd1);

    // Cycle counter load and wrap
    store(CYC, 32'hFFFFFFFE);
    rd(CYC, r); check("cycle_load", r, 32'hFFFFFFFE);
    cyc();
    rd(CYC, r); check("cycle_ffff", r, 32'hFFFFFFFF);
    cyc();
    rd(CYC, r); check("cycle_wrap", r, 32'd0);

    // Unused offsets and unmapped writes
    store(32'hF007, 32'hFFFFFFFF);
    rd(32'hF007, r); check("ofs7_read", r, 32'd0);
    rd(STS, r);      check("ofs7_no_side_status", r, 32'h1);
    rd(EDG, r);      check("ofs7_no_side_edge", r, 32'd1);
    rd(TXD, r);      check("txdata_reads_zero", r, 32'd0);
    address_dmem = 32'h8000; data = 32'h5A; wren = 1'b1; #1;
    check("unmapped_no_ram_wren", {31'b0, ram_wren}, 32'd0);
    cyc();
    wren = 1'b0;
    check("unmapped_no_push", {31'b0, tx_valid}, 32'd0);

    // Reset with queued entries
    for (int i = 0; i < 5; i++) push_word(32'h200 + 32'(i), 1'b1);
    rd(STS, r); check("status_cnt5", r, 32'hA0);
    address_dmem = CYC;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_q.delete();
    check("rst2_tx_valid", {31'b0, tx_valid}, 32'd0);
    rd(STS, r); check("rst2_status", r, 32'h1);
    rd(CYC, r); check("rst2_cycle", r, 32'd0);
    rd(INP, r); check("rst2_input", r, 32'd0);
    rd(EDG, r); check("rst2_edge", r, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
